seg7_scan_mux: RTL

- Parametrised, time-multiplexed driver for a 2*NUM_FIELDS-digit common-segment seven-segment display. Successor to the static per-digit decoder.
- Selects between wall-clock and stopwatch sources and snapshots them once per frame (tear-free).
- Converts each 6-bit field to two BCD digits, scans one digit at a time with dead-time, blinks selected fields, blanks the leading zero and drives the colon.
- Sits between the timekeeping/stopwatch counters and the board display pins.

---
 rtl/seg7_scan_mux.sv | 73 +++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed seven-segment driver with frame snapshot, blink, colon and leading-zero blank
module seg7_scan_mux #(
  parameter int NUM_FIELDS     = 3,
  parameter int SCAN_DIV       = 1000,
  parameter int DEAD_CYC       = 2,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit LZ_BLANK       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_1hz,
  input  logic                      mode,
  input  logic [6*NUM_FIELDS-1:0]   time_vals,
  input  logic [6*NUM_FIELDS-1:0]   sw_vals,
  input  logic [NUM_FIELDS-1:0]     blink_mask,
  output logic [7:0]                seg,
  output logic [2*NUM_FIELDS-1:0]   an,
  output logic                      frame_start
);
  localparam int ND = 2 * NUM_FIELDS;
  localparam int DW = $clog2(ND);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [7:0]    SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [ND-1:0] AN_OFF  = {ND{SEG_ACTIVE_LOW}};
  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [CW-1:0]           scan_cnt;
  logic [DW-1:0]           digit_idx, fld;
  logic                    blink_phase, snap_mode;
  logic [6*NUM_FIELDS-1:0] snapshot;
  logic                    slot_end, frame_end, blank, lz;
  logic [5:0]              fv;
  logic [3:0]              tens, ones, code;
  logic [7:0]              seg_n;
  logic [ND-1:0]           an_n;
  // decode the current slot into the active-high glyph and anode pattern
  always_comb begin
    fld       = digit_idx >> 1;
    slot_end  = scan_cnt == CW'(SCAN_DIV - 1);
    frame_end = slot_end && digit_idx == DW'(ND - 1);
    fv        = 6'(snapshot >> (6 * fld));
    tens      = 4'(fv / 6'd10);
    ones      = 4'(fv % 6'd10);
    code      = digit_idx[0] ? tens : ones;
    blank     = blink_phase && |(blink_mask & (NUM_FIELDS'(1) << fld));
    lz        = LZ_BLANK && digit_idx == DW'(ND - 1) && tens == 4'd0;
    seg_n     = (blank || lz || code > 4'd9) ? 8'h00
              : {!digit_idx[0] && |fld && (snap_mode || !blink_phase), GLYPH[code]};
    an_n      = (scan_cnt >= CW'(DEAD_CYC)) ? ND'(1) << digit_idx : '0;
  end
  // scan counters, frame snapshot, blink phase and registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      blink_phase <= 1'b0;
      snap_mode   <= 1'b0;
      snapshot    <= '0;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      scan_cnt    <= slot_end ? '0 : scan_cnt + CW'(1);
      digit_idx   <= frame_end ? '0 : slot_end ? digit_idx + DW'(1) : digit_idx;
      frame_start <= frame_end;
      snapshot    <= frame_end ? (mode ? sw_vals : time_vals) : snapshot;
      snap_mode   <= frame_end ? mode : snap_mode;
      blink_phase <= blink_phase ^ tick_1hz;
      seg         <= SEG_ACTIVE_LOW ? ~seg_n : seg_n;
      an          <= SEG_ACTIVE_LOW ? ~an_n : an_n;
    end
  end
endmodule
